// File: rtl/conv_layer_engine.sv
// Channel-generic convolution layer: one MAC per tap streamed from BRAM, bias read from
// the weight BRAM, optional ReLU, saturated results written to the result BRAM.
module conv_layer_engine #(
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 0,
  parameter int IMG       = 12,
  parameter int K         = 5,
  parameter int IN_CH     = 6,
  parameter int OUT_CH    = 16,
  parameter int RD_LAT    = 2,
  parameter int W_AW      = 12,
  parameter int IN_AW     = 10,
  parameter int OUT_AW    = 10,
  parameter int BIAS_BASE = 2400
) (
  input  logic                 clk,
  input  logic                 rst,
  // start is a one-cycle request taken only in IDLE; done is a one-cycle pulse that
  // follows the final result write. There is no back-pressure on either side.
  input  logic                 start,
  input  logic                 relu_en,
  output logic                 busy,
  output logic                 done,
  output logic                 bias_weights_bram_ena,
  output logic [W_AW-1:0]      bias_weights_bram_addra,
  input  logic [DATA_SIZE-1:0] bias_weights_bram_douta,
  output logic                 input_bram_ena,
  output logic [IN_AW-1:0]     input_bram_addra,
  input  logic [DATA_SIZE-1:0] input_bram_douta,
  output logic                 result_bram_wea,
  output logic [OUT_AW-1:0]    result_bram_addra,
  output logic [DATA_SIZE-1:0] result_bram_dina,
  output logic [2:0]           o_dbg_state
);

  localparam int OUT   = IMG - K + 1;
  localparam int TAPS  = IN_CH * K * K;
  localparam int ACC_W = 2 * DATA_SIZE + $clog2(TAPS) + 1;
  localparam int CW    = 16;

  localparam logic [CW-1:0] K_LAST   = CW'(K - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(IN_CH - 1);
  localparam logic [CW-1:0] O_LAST   = CW'(OUT - 1);
  localparam logic [CW-1:0] F_LAST   = CW'(OUT_CH - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(RD_LAT);

  localparam logic [31:0] W_F_STRIDE = 32'(TAPS);
  localparam logic [31:0] KK         = 32'(K * K);
  localparam logic [31:0] K32        = 32'(K);
  localparam logic [31:0] IMG32      = 32'(IMG);
  localparam logic [31:0] IMG2       = 32'(IMG * IMG);
  localparam logic [31:0] OUT32      = 32'(OUT);
  localparam logic [31:0] OO         = 32'(OUT * OUT);
  localparam logic [31:0] BB32       = 32'(BIAS_BASE);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_SIZE - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_TAP   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic                    r_relu;
  logic [CW-1:0]           r_lat;
  logic [CW-1:0]           r_f, r_r, r_c, r_ch, r_ky, r_kx;
  logic signed [ACC_W-1:0] r_acc;
  logic [DATA_SIZE-1:0]    r_bias;
  logic                    r_busy, r_done;
  logic                    r_w_ena, r_i_ena, r_wea;
  logic [W_AW-1:0]         r_w_addr;
  logic [IN_AW-1:0]        r_i_addr;
  logic [OUT_AW-1:0]       r_res_addr;
  logic [DATA_SIZE-1:0]    r_res_data;

  logic                    w_tap_last, w_pix_last, w_f_last;
  logic [CW-1:0]           w_nkx, w_nky, w_nch, w_nc, w_nr;
  logic [CW-1:0]           w_ir, w_ic, w_ich, w_iky, w_ikx, w_bf;
  logic [W_AW-1:0]         w_waddr, w_baddr;
  logic [IN_AW-1:0]        w_iaddr;
  logic [OUT_AW-1:0]       w_raddr;
  logic signed [2*DATA_SIZE-1:0] w_prod;
  logic signed [ACC_W-1:0] w_acc_next, w_shift, w_y, w_bias_in, w_bias_hold;
  logic [DATA_SIZE-1:0]    w_sat;

  // Loop bookkeeping: successor of the current tap and of the current pixel.
  always_comb begin
    w_tap_last = (r_ch == CH_LAST) && (r_ky == K_LAST) && (r_kx == K_LAST);
    w_pix_last = (r_r == O_LAST) && (r_c == O_LAST);
    w_f_last   = (r_f == F_LAST);
    w_nkx = r_kx + CW'(1);
    w_nky = r_ky;
    w_nch = r_ch;
    if (r_kx == K_LAST) begin
      w_nkx = '0;
      w_nky = r_ky + CW'(1);
      if (r_ky == K_LAST) begin
        w_nky = '0;
        w_nch = r_ch + CW'(1);
      end
    end
    w_nc = r_c + CW'(1);
    w_nr = r_r;
    if (r_c == O_LAST) begin
      w_nc = '0;
      w_nr = r_r + CW'(1);
    end
  end

  // Indices of the next read to issue; tap indices restart at 0 on every new pixel.
  always_comb begin
    w_ir  = r_r;
    w_ic  = r_c;
    w_ich = '0;
    w_iky = '0;
    w_ikx = '0;
    if (r_state == S_TAP) begin
      w_ich = w_nch;
      w_iky = w_nky;
      w_ikx = w_nkx;
    end else if (r_state == S_WRITE) begin
      w_ir = w_nr;
      w_ic = w_nc;
    end
    w_bf    = (r_state == S_IDLE) ? '0 : r_f + CW'(1);
    w_waddr = W_AW'(32'(r_f) * W_F_STRIDE + 32'(w_ich) * KK + 32'(w_iky) * K32 + 32'(w_ikx));
    w_iaddr = IN_AW'(32'(w_ich) * IMG2 + (32'(w_ir) + 32'(w_iky)) * IMG32 + 32'(w_ic) + 32'(w_ikx));
    w_baddr = W_AW'(BB32 + 32'(w_bf));
    w_raddr = OUT_AW'(32'(r_f) * OO + 32'(r_r) * OUT32 + 32'(r_c));
  end

  assign w_prod      = $signed(input_bram_douta) * $signed(bias_weights_bram_douta);
  assign w_acc_next  = r_acc + ACC_W'(w_prod);
  assign w_shift     = w_acc_next >>> FRAC_BITS;
  assign w_bias_in   = ACC_W'($signed(bias_weights_bram_douta)) <<< FRAC_BITS;
  assign w_bias_hold = ACC_W'($signed(r_bias)) <<< FRAC_BITS;

  always_comb begin
    w_y = w_shift;
    if (r_relu && (w_shift < 0)) w_y = '0;
    if (w_y > SAT_MAX)      w_sat = SAT_MAX[DATA_SIZE-1:0];
    else if (w_y < SAT_MIN) w_sat = SAT_MIN[DATA_SIZE-1:0];
    else                    w_sat = w_y[DATA_SIZE-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_relu     <= 1'b0;
      r_lat      <= '0;
      r_f        <= '0;
      r_r        <= '0;
      r_c        <= '0;
      r_ch       <= '0;
      r_ky       <= '0;
      r_kx       <= '0;
      r_acc      <= '0;
      r_bias     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_w_ena    <= 1'b0;
      r_i_ena    <= 1'b0;
      r_wea      <= 1'b0;
      r_w_addr   <= '0;
      r_i_addr   <= '0;
      r_res_addr <= '0;
      r_res_data <= '0;
    end else begin
      // Strobes are single-cycle; addresses keep their last value.
      r_w_ena <= 1'b0;
      r_i_ena <= 1'b0;
      r_wea   <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_BIAS;
            r_busy   <= 1'b1;
            r_relu   <= relu_en;
            r_lat    <= '0;
            r_f      <= '0;
            r_r      <= '0;
            r_c      <= '0;
            r_ch     <= '0;
            r_ky     <= '0;
            r_kx     <= '0;
            r_w_ena  <= 1'b1;
            r_w_addr <= w_baddr;
          end
        end
        S_BIAS: begin
          if (r_lat == LAT_LAST) begin
            r_bias   <= bias_weights_bram_douta;
            r_acc    <= w_bias_in;
            r_lat    <= '0;
            r_state  <= S_TAP;
            r_w_ena  <= 1'b1;
            r_w_addr <= w_waddr;
            r_i_ena  <= 1'b1;
            r_i_addr <= w_iaddr;
          end else begin
            r_lat <= r_lat + CW'(1);
          end
        end
        S_TAP: begin
          if (r_lat == LAT_LAST) begin
            r_acc <= w_acc_next;
            r_lat <= '0;
            if (w_tap_last) begin
              r_state    <= S_WRITE;
              r_wea      <= 1'b1;
              r_res_addr <= w_raddr;
              r_res_data <= w_sat;
              r_ch       <= '0;
              r_ky       <= '0;
              r_kx       <= '0;
            end else begin
              r_ch     <= w_nch;
              r_ky     <= w_nky;
              r_kx     <= w_nkx;
              r_w_ena  <= 1'b1;
              r_w_addr <= w_waddr;
              r_i_ena  <= 1'b1;
              r_i_addr <= w_iaddr;
            end
          end else begin
            r_lat <= r_lat + CW'(1);
          end
        end
        S_WRITE: begin
          r_lat <= '0;
          if (!w_pix_last) begin
            r_r      <= w_nr;
            r_c      <= w_nc;
            r_acc    <= w_bias_hold;
            r_state  <= S_TAP;
            r_w_ena  <= 1'b1;
            r_w_addr <= w_waddr;
            r_i_ena  <= 1'b1;
            r_i_addr <= w_iaddr;
          end else if (!w_f_last) begin
            r_f      <= r_f + CW'(1);
            r_r      <= '0;
            r_c      <= '0;
            r_state  <= S_BIAS;
            r_w_ena  <= 1'b1;
            r_w_addr <= w_baddr;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy                    = r_busy;
  assign done                    = r_done;
  assign bias_weights_bram_ena   = r_w_ena;
  assign bias_weights_bram_addra = r_w_addr;
  assign input_bram_ena          = r_i_ena;
  assign input_bram_addra        = r_i_addr;
  assign result_bram_wea         = r_wea;
  assign result_bram_addra       = r_res_addr;
  assign result_bram_dina        = r_res_data;
  assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Bench for conv_layer_engine: table-driven constant-fill runs, hand-written corner
// sequences, and random runs checked against a loop-level convolution model.
module tb_conv_layer_engine;

  localparam int IMG = 4, K = 3, IN_CH = 2, OUT_CH = 2, RD_LAT = 2, BB = 2400;
  localparam int OUT = IMG - K + 1;
  localparam int EXP_CYC = 1 + OUT_CH * ((RD_LAT + 1) + OUT * OUT * (IN_CH * K * K * (RD_LAT + 1) + 1)) + 1;
  localparam int N_WR = OUT_CH * OUT * OUT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, relu_en = 1'b0;

  logic        busy0, done0, w_ena0, i_ena0, wea0;
  logic [11:0] w_addr0;
  logic [9:0]  i_addr0, r_addr0;
  logic [15:0] w_dout0, i_dout0, r_data0;
  logic [2:0]  dbg0;
  logic        busy1, done1, w_ena1, i_ena1, wea1;
  logic [11:0] w_addr1;
  logic [9:0]  i_addr1, r_addr1;
  logic [15:0] w_dout1, i_dout1, r_data1;
  logic [2:0]  dbg1;

  logic signed [15:0] wmem [0:4095];
  logic signed [15:0] imem [0:1023];
  logic [15:0] wp0 [0:1], ip0 [0:1], wp1 [0:1], ip1 [0:1];

  logic [25:0] exp_q [$];
  logic [25:0] got0_q [$];
  logic [25:0] got1_q [$];
  int done_cnt0 = 0, done_cnt1 = 0;
  int n_pass = 0, n_total = 0;

  typedef struct {
    logic [15:0] in_v, w_v, b0, b1;
    bit          relu;
    logic [15:0] exp0, exp1;
  } vec_t;
  vec_t vecs [7];

  conv_layer_engine #(.DATA_SIZE(16), .FRAC_BITS(0), .IMG(IMG), .K(K), .IN_CH(IN_CH),
    .OUT_CH(OUT_CH), .RD_LAT(RD_LAT), .W_AW(12), .IN_AW(10), .OUT_AW(10), .BIAS_BASE(BB)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .relu_en(relu_en), .busy(busy0), .done(done0),
    .bias_weights_bram_ena(w_ena0), .bias_weights_bram_addra(w_addr0), .bias_weights_bram_douta(w_dout0),
    .input_bram_ena(i_ena0), .input_bram_addra(i_addr0), .input_bram_douta(i_dout0),
    .result_bram_wea(wea0), .result_bram_addra(r_addr0), .result_bram_dina(r_data0),
    .o_dbg_state(dbg0));

  conv_layer_engine #(.DATA_SIZE(16), .FRAC_BITS(8), .IMG(IMG), .K(K), .IN_CH(IN_CH),
    .OUT_CH(OUT_CH), .RD_LAT(RD_LAT), .W_AW(12), .IN_AW(10), .OUT_AW(10), .BIAS_BASE(BB)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .relu_en(relu_en), .busy(busy1), .done(done1),
    .bias_weights_bram_ena(w_ena1), .bias_weights_bram_addra(w_addr1), .bias_weights_bram_douta(w_dout1),
    .input_bram_ena(i_ena1), .input_bram_addra(i_addr1), .input_bram_douta(i_dout1),
    .result_bram_wea(wea1), .result_bram_addra(r_addr1), .result_bram_dina(r_data1),
    .o_dbg_state(dbg1));

  // Clock / behavioural two-cycle-latency BRAMs
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_ena0) wp0[0] <= wmem[w_addr0];
    if (i_ena0) ip0[0] <= imem[i_addr0];
    if (w_ena1) wp1[0] <= wmem[w_addr1];
    if (i_ena1) ip1[0] <= imem[i_addr1];
    wp0[1] <= wp0[0];
    ip0[1] <= ip0[0];
    wp1[1] <= wp1[0];
    ip1[1] <= ip1[0];
  end
  assign w_dout0 = wp0[1];
  assign i_dout0 = ip0[1];
  assign w_dout1 = wp1[1];
  assign i_dout1 = ip1[1];

  // Write / done monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (wea0) got0_q.push_back({r_addr0, r_data0});
    if (wea1) got1_q.push_back({r_addr1, r_data1});
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic fill(input logic [15:0] iv, input logic [15:0] wv, input logic [15:0] b0,
                      input logic [15:0] b1);
    for (int a = 0; a < 1024; a++) imem[a] = iv;
    for (int a = 0; a < 4096; a++) wmem[a] = wv;
    wmem[BB] = b0;
    wmem[BB + 1] = b1;
  endtask

  // Reference: direct convolution sum per output pixel in plain integer arithmetic.
  task automatic build_exp(input bit relu, input int frac);
    longint acc, y;
    logic [15:0] yv;
    exp_q.delete();
    for (int f = 0; f < OUT_CH; f++)
      for (int r = 0; r < OUT; r++)
        for (int c = 0; c < OUT; c++) begin
          acc = longint'(wmem[BB + f]) * (longint'(1) << frac);
          for (int ch = 0; ch < IN_CH; ch++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++)
                acc += longint'(imem[ch * IMG * IMG + (r + ky) * IMG + c + kx]) *
                       longint'(wmem[f * IN_CH * K * K + ch * K * K + ky * K + kx]);
          y = acc >>> frac;
          if (relu && y < 0) y = 0;
          if (y > 32767) y = 32767;
          if (y < -32768) y = -32768;
          yv = y[15:0];
          exp_q.push_back({10'(f * OUT * OUT + r * OUT + c), yv});
        end
  endtask

  task automatic run(input int sel, input bit relu, input bit extra, output int cycles);
    int n;
    @(negedge clk);
    relu_en = relu;
    if (sel == 0) start0 = 1'b1;
    else start1 = 1'b1;
    n = 1;
    do begin
      @(negedge clk);
      n++;
      start0 = (sel == 0) && extra && (n == 50 || n == 300 || n == EXP_CYC);
      start1 = (sel == 1) && extra && (n == 50 || n == 300 || n == EXP_CYC);
    end while (!((sel == 0) ? done0 : done1) && n < 3000);
    start0 = 1'b0;
    start1 = 1'b0;
    cycles = n;
    @(negedge clk);
  endtask

  task automatic cmp_writes(input string tag, input int sel, input int base);
    int sz;
    logic [25:0] g;
    sz = (sel == 0) ? got0_q.size() : got1_q.size();
    check({tag, " write count"}, 64'(sz - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < sz) g = (sel == 0) ? got0_q[base + i] : got1_q[base + i];
      else g = '1;
      check($sformatf("%s write %0d {addr,data}", tag, i), 64'(g), 64'(exp_q[i]));
    end
  endtask

  task automatic table_exp(input logic [15:0] e0, input logic [15:0] e1);
    exp_q.delete();
    for (int i = 0; i < N_WR; i++) exp_q.push_back({10'(i), (i < N_WR / 2) ? e0 : e1});
  endtask

  initial begin
    int cyc, base, dbase;
    bit rl;
    vecs[0] = '{16'd1,      16'd1,      16'd0, 16'd0,      1'b0, 16'd18,     16'd18};
    vecs[1] = '{16'd1,      16'd1,      16'd0, 16'hFFEC,   1'b0, 16'd18,     16'hFFFE};
    vecs[2] = '{16'd1,      16'd1,      16'd0, 16'hFFEC,   1'b1, 16'd18,     16'd0};
    vecs[3] = '{16'h7FFF,   16'h7FFF,   16'd0, 16'd0,      1'b0, 16'h7FFF,   16'h7FFF};
    vecs[4] = '{16'h7FFF,   16'h8001,   16'd0, 16'd0,      1'b0, 16'h8000,   16'h8000};
    vecs[5] = '{16'hFFFF,   16'd1,      16'd5, 16'd0,      1'b0, 16'hFFF3,   16'hFFEE};
    vecs[6] = '{16'hFFFF,   16'd1,      16'd5, 16'd0,      1'b1, 16'd0,      16'd0};
    fill(16'd0, 16'd0, 16'd0, 16'd0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", {busy0, done0, w_ena0, w_addr0, i_ena0, i_addr0, wea0, r_addr0, r_data0}, 64'd0);
    check("reset state idle", 64'(dbg0), 64'd0);
    rst = 1'b0;

    // Table-driven constant fills
    for (int v = 0; v < 7; v++) begin
      fill(vecs[v].in_v, vecs[v].w_v, vecs[v].b0, vecs[v].b1);
      table_exp(vecs[v].exp0, vecs[v].exp1);
      base = got0_q.size();
      dbase = done_cnt0;
      run(0, vecs[v].relu, 1'b0, cyc);
      check($sformatf("vec%0d run cycles", v), 64'(cyc), 64'(EXP_CYC));
      check($sformatf("vec%0d done pulses", v), 64'(done_cnt0 - dbase), 64'd1);
      check($sformatf("vec%0d busy after done", v), 64'(busy0), 64'd0);
      cmp_writes($sformatf("vec%0d", v), 0, base);
    end

    // Ramp input, one-hot centre weights: out = centre pixel of channel f
    for (int a = 0; a < 1024; a++) imem[a] = 16'(a);
    for (int a = 0; a < 4096; a++) wmem[a] = 16'd0;
    wmem[0 * 18 + 0 * 9 + 4] = 16'd1;
    wmem[1 * 18 + 1 * 9 + 4] = 16'd1;
    exp_q.delete();
    for (int i = 0; i < N_WR; i++)
      exp_q.push_back({10'(i), 16'((i / 4) * 16 + ((i % 4) / 2 + 1) * 4 + (i % 2) + 1)});
    base = got0_q.size();
    run(0, 1'b0, 1'b0, cyc);
    cmp_writes("ramp", 0, base);

    // Reset mid-TAP of filter 1, then a clean rerun
    fill(16'd1, 16'd1, 16'd0, 16'd0);
    base = got0_q.size();
    dbase = done_cnt0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int t = 0; t < 1000 && got0_q.size() < base + 4; t++) @(negedge clk);
    check("abort: filter0 writes before reset", 64'(got0_q.size() - base), 64'd4);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort: outputs zero", {busy0, done0, w_ena0, w_addr0, i_ena0, i_addr0, wea0, r_addr0, r_data0}, 64'd0);
    check("abort: state idle", 64'(dbg0), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort: no extra writes", 64'(got0_q.size() - base), 64'd4);
    check("abort: no done", 64'(done_cnt0 - dbase), 64'd0);
    table_exp(16'd18, 16'd18);
    base = got0_q.size();
    run(0, 1'b0, 1'b0, cyc);
    check("rerun cycles", 64'(cyc), 64'(EXP_CYC));
    cmp_writes("rerun", 0, base);

    // start coincident with rst: rst wins
    @(negedge clk);
    rst = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    @(negedge clk);
    check("start under rst: busy", 64'(busy0), 64'd0);

    // start pulses while busy are ignored
    base = got0_q.size();
    dbase = done_cnt0;
    run(0, 1'b0, 1'b1, cyc);
    repeat (5) @(negedge clk);
    check("busy-start: cycles", 64'(cyc), 64'(EXP_CYC));
    check("busy-start: done pulses", 64'(done_cnt0 - dbase), 64'd1);
    check("busy-start: writes", 64'(got0_q.size() - base), 64'(N_WR));
    check("busy-start: idle after", 64'(busy0), 64'd0);

    // FRAC_BITS=8 instance with 1.0 * 1.0 taps
    fill(16'd256, 16'd256, 16'd0, 16'd0);
    table_exp(16'(18 << 8), 16'(18 << 8));
    base = got1_q.size();
    run(1, 1'b0, 1'b0, cyc);
    check("frac8 cycles", 64'(cyc), 64'(EXP_CYC));
    check("frac8 done pulses", 64'(done_cnt1), 64'd1);
    cmp_writes("frac8", 1, base);

    // Random runs against the reference model
    for (int it = 0; it < 5; it++) begin
      for (int a = 0; a < 1024; a++)
        imem[a] = (it == 4) ? 16'($urandom) : 16'(int'($urandom_range(0, 600)) - 300);
      for (int a = 0; a < IN_CH * K * K * OUT_CH; a++)
        wmem[a] = (it == 4) ? 16'($urandom) : 16'(int'($urandom_range(0, 600)) - 300);
      wmem[BB] = 16'(int'($urandom_range(0, 4000)) - 2000);
      wmem[BB + 1] = 16'(int'($urandom_range(0, 4000)) - 2000);
      rl = 1'($urandom_range(0, 1));
      build_exp(rl, 0);
      base = got0_q.size();
      run(0, rl, 1'b0, cyc);
      check($sformatf("rand%0d cycles", it), 64'(cyc), 64'(EXP_CYC));
      cmp_writes($sformatf("rand%0d", it), 0, base);
    end

    // Random FRAC_BITS=8 run
    for (int a = 0; a < 1024; a++) imem[a] = 16'(int'($urandom_range(0, 2000)) - 1000);
    for (int a = 0; a < IN_CH * K * K * OUT_CH; a++) wmem[a] = 16'(int'($urandom_range(0, 2000)) - 1000);
    wmem[BB] = 16'(int'($urandom_range(0, 200)) - 100);
    wmem[BB + 1] = 16'(int'($urandom_range(0, 200)) - 100);
    build_exp(1'b1, 8);
    base = got1_q.size();
    run(1, 1'b1, 1'b0, cyc);
    cmp_writes("rand_frac8", 1, base);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
